uart_tx_axis_fifo: RTL and testbench

Parametrised next-generation UART transmitter with an AXI-Stream input. It has a built-in input FIFO, selectable parity (none/even/odd), and 1 or 2 stop bits. Parity and stop-bit settings are sampled per frame. It sits between an AXI-Stream producer and the serial TX pin, and it sends queued words back-to-back with no idle gap.

---
 rtl/uart_tx_axis_fifo_pkg.sv | 27 ++
 rtl/uart_tx_axis_fifo_if.sv | 15 +
 rtl/uart_tx_axis_fifo_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_axis_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_axis_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_axis_fifo_pkg.sv
// uart_pkg: types and helpers shared by the UART TX slice (and a future RX side).
//   parity_t       - cfg_parity encoding (11 behaves as no parity)
//   tx_state_t     - transmitter FSM states
//   clocks_per_bit - integer clock cycles per serial bit
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10,
        PARITY_RSVD = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned clocks_per_bit(input int unsigned freq,
                                                   input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_axis_fifo_if.sv
// AXI-Stream word channel feeding the UART transmitter.
//   tdata  - word to transmit
//   tvalid - producer has a word
//   tready - consumer can accept a word
// master: producer side, slave: UART side.
interface uart_tx_axis_fifo_if #(
    parameter int unsigned WORD_WIDTH = 8
) ();
    logic [WORD_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_axis_fifo_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered status flags.
//   clk, rst        - clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data   - write request; ignored while full
//   pop, rd_data    - read request; ignored while empty; rd_data is the head word
//   full, empty     - registered status
//   level           - number of stored words
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_axis_fifo.sv
// uart_tx_axis_fifo: UART transmitter with an AXI-Stream input and input FIFO.
//   clk, rst       - clock, synchronous active-high reset
//   din_axis       - AXI-Stream slave (tdata/tvalid in, tready = FIFO not full)
//   cfg_parity     - 00 none, 01 even, 10 odd, 11 none; sampled when a word is popped
//   cfg_two_stop   - 1 selects two stop bits; sampled when a word is popped
//   dout           - registered serial line, idle high, LSB first
//   busy           - high while the FSM is not IDLE
//   fifo_level     - words waiting in the FIFO (excludes the word on the line)
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | sending the start bit (0)
// DATA   | sending data bits, LSB first, bit_idx selects the bit
// PARITY | sending the parity bit
// STOP   | sending stop bit(s); chains straight into START if a word is queued
module uart_tx_axis_fifo #(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter int unsigned FIFO_DEPTH      = 32'd4
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_axis_fifo_if.slave              din_axis,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_two_stop,
    output logic                            dout,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    import uart_pkg::*;

    localparam int unsigned CPB = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned CW  = $clog2(CPB);
    localparam int unsigned IW  = $clog2(WORD_WIDTH);

    tx_state_t             state;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         bit_idx;
    logic [WORD_WIDTH-1:0] frame_data;
    logic                  par_en;
    logic                  par_bit;
    logic                  two_stop;

    logic [WORD_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  last_cycle;
    logic                  last_stop;
    logic                  pop;
    parity_t               cfg_par;

    assign cfg_par         = parity_t'(cfg_parity);
    assign din_axis.tready = !fifo_full;

    uart_sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (din_axis.tvalid),
        .wr_data (din_axis.tdata),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign last_cycle = (bit_cnt == CW'(CPB - 1));
    assign last_stop  = last_cycle && (bit_idx == {{(IW-1){1'b0}}, two_stop});
    // Pop from IDLE, or on the final stop cycle so the next start bit follows with no gap.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && last_stop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            frame_data <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            two_stop   <= 1'b0;
            dout       <= 1'b1;
            busy       <= 1'b0;
        end else begin
            // The line shows the bit of the state just left, so dout trails the FSM by one clock.
            case (state)
                START:   dout <= 1'b0;
                DATA:    dout <= frame_data[bit_idx];
                PARITY:  dout <= par_bit;
                default: dout <= 1'b1;
            endcase

            if (pop) begin
                frame_data <= fifo_rd_data;
                par_en     <= (cfg_par == PARITY_EVEN) || (cfg_par == PARITY_ODD);
                par_bit    <= (^fifo_rd_data) ^ (cfg_par == PARITY_ODD);
                two_stop   <= cfg_two_stop;
            end

            if (state == IDLE || last_cycle) bit_cnt <= '0;
            else                             bit_cnt <= bit_cnt + CW'(1);

            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (pop) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (last_cycle) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (last_cycle) begin
                        if (bit_idx == IW'(WORD_WIDTH - 1)) begin
                            bit_idx <= '0;
                            state   <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (last_cycle) begin
                        state   <= STOP;
                        bit_idx <= '0;
                    end
                end
                STOP: begin
                    if (last_cycle) begin
                        if (last_stop) begin
                            bit_idx <= '0;
                            if (pop) begin
                                state <= START;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_axis_fifo.sv
// Bench for uart_tx_axis_fifo: 10 clocks/bit, 8-bit instance (a) and 5-bit instance (b).
module tb_uart_tx_axis_fifo;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_axis_fifo_if #(.WORD_WIDTH(8)) ax ();
    uart_tx_axis_fifo_if #(.WORD_WIDTH(5)) bx ();

    logic [1:0] par_a, par_b;
    logic       two_a, two_b;
    logic       dout_a, dout_b, busy_a, busy_b;
    logic [2:0] lvl_a, lvl_b;

    uart_tx_axis_fifo #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
                        .WORD_WIDTH(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .din_axis(ax), .cfg_parity(par_a), .cfg_two_stop(two_a),
        .dout(dout_a), .busy(busy_a), .fifo_level(lvl_a));

    uart_tx_axis_fifo #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
                        .WORD_WIDTH(5), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .din_axis(bx), .cfg_parity(par_b), .cfg_two_stop(two_b),
        .dout(dout_b), .busy(busy_b), .fifo_level(lvl_b));

    int total = 0;
    int bad   = 0;
    logic [8:0] sb [$];

    int busy_hi_a = 0;
    always @(negedge clk) if (busy_a === 1'b1) busy_hi_a <= busy_hi_a + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel == 0) ? dout_a : dout_b;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ax.tready : bx.tready;
    endfunction

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic int build_frame(input logic [8:0] d, input int ww, input logic [1:0] par,
                                       input logic two, output logic [15:0] fb);
        int n;
        logic x;
        fb = '1;
        fb[0] = 1'b0;
        x = 1'b0;
        for (int i = 0; i < ww; i++) begin
            fb[1+i] = d[i];
            x = x ^ d[i];
        end
        n = 1 + ww;
        if (par == 2'b01 || par == 2'b10) begin
            fb[n] = (par == 2'b10) ? ~x : x;
            n++;
        end
        fb[n] = 1'b1;
        n++;
        if (two) begin
            fb[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic push(input int sel, input logic [8:0] d, output int acc);
        int k;
        if (sel == 0) begin ax.tdata = d[7:0]; ax.tvalid = 1'b1; end
        else          begin bx.tdata = d[4:0]; bx.tvalid = 1'b1; end
        k = 0;
        while (!rdy(sel) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            chk("push_timeout", 0, 1);
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            sb.push_back((sel == 0) ? {1'b0, d[7:0]} : {4'b0, d[4:0]});
            @(negedge clk);
        end
        if (sel == 0) ax.tvalid = 1'b0;
        else          bx.tvalid = 1'b0;
    endtask

    // Waits for a start bit, then compares every cycle of the frame against the reference.
    task automatic watch(input int sel, input int ww, input logic [1:0] par, input logic two,
                         output int st, output int en, output int parv);
        int k, n, nb;
        logic [8:0] d;
        logic [15:0] fb;
        parv = -1;
        k = 0;
        while (line(sel) !== 1'b0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (k >= 600) begin
            chk("start_timeout", 0, 1);
            st = -1;
            en = -1;
            return;
        end
        if (sb.size() == 0) begin
            chk("unexpected_frame", 0, 1);
            d = '0;
        end else begin
            d = sb.pop_front();
        end
        n  = build_frame(d, ww, par, two, fb);
        st = cyc;
        en = cyc;
        nb = 0;
        for (int i = 0; i < n * CPB; i++) begin
            if (line(sel) !== fb[i / CPB]) nb++;
            if ((par == 2'b01 || par == 2'b10) && i == (1 + ww) * CPB + CPB / 2)
                parv = int'(line(sel));
            en = cyc;
            @(negedge clk);
        end
        chk("frame_bits", nb, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       two;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t tbl [7];
    int acc, st, en, pv, b0, st2, en2, pv2;
    int acc3 [6];
    int st3 [6];
    int en3 [6];
    logic [7:0] w6 [6];
    int zeros, r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h55, 2'b00, 1'b0, 100, -1};
        tbl[1] = '{8'h07, 2'b01, 1'b1, 120,  1};
        tbl[2] = '{8'h07, 2'b10, 1'b1, 120,  0};
        tbl[3] = '{8'hA3, 2'b11, 1'b0, 100, -1};
        tbl[4] = '{8'hFF, 2'b10, 1'b0, 110,  1};
        tbl[5] = '{8'h00, 2'b01, 1'b0, 110,  0};
        tbl[6] = '{8'h80, 2'b01, 1'b1, 120,  1};

        rst = 1'b1;
        ax.tvalid = 1'b0; ax.tdata = '0;
        bx.tvalid = 1'b0; bx.tdata = '0;
        par_a = 2'b00; two_a = 1'b0; par_b = 2'b00; two_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_dout", int'(dout_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_level", int'(lvl_a), 0);
        chk("rst_tready", int'(ax.tready), 1);
        chk("rst_dout_b", int'(dout_b), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from the table.
        for (int v = 0; v < 7; v++) begin
            par_a = tbl[v].par;
            two_a = tbl[v].two;
            b0 = busy_hi_a;
            fork
                push(0, {1'b0, tbl[v].data}, acc);
                watch(0, 8, tbl[v].par, tbl[v].two, st, en, pv);
            join
            chk($sformatf("v%0d_latency", v), st - acc, 2);
            chk($sformatf("v%0d_len", v), en - st + 1, tbl[v].exp_len);
            chk($sformatf("v%0d_parity", v), pv, tbl[v].exp_par);
            @(negedge clk);
            chk($sformatf("v%0d_busy_cycles", v), busy_hi_a - b0, tbl[v].exp_len);
            chk($sformatf("v%0d_idle", v), int'({busy_a, dout_a}), 1);
        end

        // tvalid held with 6 words: fill to full, then back-to-back frames.
        par_a = 2'b00; two_a = 1'b0;
        r = $urandom_range(0, 255);
        for (int i = 0; i < 6; i++) w6[i] = 8'(i * 37 + r);
        fork
            begin
                int i, k;
                i = 0; k = 0;
                ax.tdata = w6[0];
                ax.tvalid = 1'b1;
                while (i < 6 && k < 1000) begin
                    if (ax.tready) begin
                        @(posedge clk);
                        #1;
                        acc3[i] = cyc;
                        sb.push_back({1'b0, w6[i]});
                        i++;
                        @(negedge clk);
                        if (i < 6) ax.tdata = w6[i];
                        else       ax.tvalid = 1'b0;
                        if (i == 5) begin
                            chk("full_tready", int'(ax.tready), 0);
                            chk("full_level", int'(lvl_a), 4);
                        end
                    end else begin
                        @(negedge clk);
                    end
                    k++;
                end
                ax.tvalid = 1'b0;
                if (i < 6) chk("burst_accepts", i, 6);
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    watch(0, 8, 2'b00, 1'b0, st3[j], en3[j], pv);
                    if (j > 0) chk($sformatf("burst_gap%0d", j), st3[j], en3[j-1] + 1);
                end
            end
        join
        chk("burst_first_latency", st3[0] - acc3[0], 2);
        chk("burst_consecutive", acc3[4] - acc3[0], 4);
        chk("burst_sixth_accept", acc3[5], en3[0] + 1);
        chk("burst_end_level", int'(lvl_a), 0);

        // Parity config changed during frame 1 data bits; frame 2 picks it up.
        @(negedge clk);
        par_a = 2'b00;
        fork
            begin
                push(0, 9'h0C3, acc);
                push(0, 9'h01E, acc);
                repeat (40) @(negedge clk);
                par_a = 2'b01;
            end
            begin
                watch(0, 8, 2'b00, 1'b0, st, en, pv);
                watch(0, 8, 2'b01, 1'b0, st2, en2, pv2);
            end
        join
        chk("cfg_f1_len", en - st + 1, 100);
        chk("cfg_f2_len", en2 - st2 + 1, 110);
        chk("cfg_f2_parity", pv2, 0);
        chk("cfg_gap", st2, en + 1);
        par_a = 2'b00;

        // Reset during bit 3 of frame 1 with two words queued.
        @(negedge clk);
        push(0, 9'h0A5, acc);
        push(0, 9'h05A, acc);
        push(0, 9'h0F0, acc);
        chk("rst_mid_frame_started", int'(dout_a), 0);
        repeat (44) @(negedge clk);
        chk("rst_mid_level_before", int'(lvl_a), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_dout", int'(dout_a), 1);
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_level", int'(lvl_a), 0);
        sb.delete();
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dout_a !== 1'b1) zeros++;
        end
        chk("rst_mid_quiet", zeros, 0);

        // Randomised bursts against the reference frame builder.
        for (int b = 0; b < 3; b++) begin
            par_a = 2'($urandom_range(0, 3));
            two_a = 1'($urandom_range(0, 1));
            fork
                begin
                    int a2;
                    for (int i = 0; i < 6; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        push(0, 9'($urandom_range(0, 255)), a2);
                    end
                end
                begin
                    for (int j = 0; j < 6; j++) begin
                        watch(0, 8, par_a, two_a, st, en, pv);
                        chk($sformatf("rnd%0d_len%0d", b, j), en - st + 1,
                            CPB * (10 + ((par_a == 2'b01 || par_a == 2'b10) ? 1 : 0) + int'(two_a)));
                    end
                end
            join
            @(negedge clk);
            chk($sformatf("rnd%0d_idle", b), int'({busy_a, lvl_a}), 0);
        end

        // 5-bit word, odd parity.
        par_b = 2'b10; two_b = 1'b0;
        fork
            push(1, 9'b0_0001_0110, acc);
            watch(1, 5, 2'b10, 1'b0, st, en, pv);
        join
        chk("w5_latency", st - acc, 2);
        chk("w5_len", en - st + 1, 80);
        chk("w5_parity", pv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
